// File: rtl/conv1d_pkg.sv
// Shared types and elaboration-time helpers for the Conv1D index sequencer.
package conv1d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Internal width of the running index registers; outputs are cast down to the port widths.
    localparam int IdxW = 16;

    function automatic int calc_output_nums(input int in_n, input int w_n, input int dil,
                                            input int str, input int pad);
        return (in_n + 2 * pad - dil * (w_n - 1) - 1) / str + 1;
    endfunction

    function automatic int ch_idx_width(input int ch_n);
        return $clog2(ch_n) + 1;
    endfunction

    function automatic int min_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv1d_nested_counter.sv
// One level of the k/c/o loop nest: a modulo counter plus two running multiples of its count.
// Next-state values are exported so the parent can register its indices on the same edge.
module conv1d_nested_counter #(
    parameter int Count  = 1,
    parameter int Step_A = 1,
    parameter int Step_B = 1,
    parameter int VW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [VW-1:0] cnt_d_o,
    output logic [VW-1:0] a_d_o,
    output logic [VW-1:0] b_d_o,
    output logic          last_q_o,
    output logic          last_d_o
);
    logic [VW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] a_q, a_d;
    logic [VW-1:0] b_q, b_d;

    assign last_q_o = (cnt_q == VW'(Count - 1));

    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        if (clr_i || (inc_i && last_q_o)) begin
            cnt_d = '0;
            a_d   = '0;
            b_d   = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + VW'(1);
            a_d   = a_q + VW'(Step_A);
            b_d   = b_q + VW'(Step_B);
        end
    end

    assign last_d_o = (cnt_d == VW'(Count - 1));
    assign cnt_d_o  = cnt_d;
    assign a_d_o    = a_d;
    assign b_d_o    = b_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/conv1d_index_gen.sv
// Conv1D address sequencer: walks (output, channel, weight-group) and emits registered indices.
// Optional zero padding (input_is_pad, Pad parameter) is built when CONV1D_IDX_PAD_EN is defined.
module conv1d_index_gen
    import conv1d_pkg::*;
#(
    parameter int Weight_Nums       = 4,
    parameter int Input_Nums        = 8,
    parameter int Channel_Nums      = 1,
    parameter int Stride            = 1,
    parameter int Dilation          = 1,
    parameter int Para_Deg          = 1,
    parameter int Weight_Addr_Width = 3,
    parameter int Input_Addr_Width  = 4,
    parameter int Output_Addr_Width = 3
`ifdef CONV1D_IDX_PAD_EN
    , parameter int Pad             = 1
`endif
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    idx_ready,
    output logic                                    idx_valid,
    output logic                                    busy,
    output logic                                    done,
    output logic [Weight_Addr_Width-1:0]            weight_index,
    output logic [Input_Addr_Width-1:0]             input_index,
    output logic [Output_Addr_Width-1:0]            output_index,
    output logic [ch_idx_width(Channel_Nums)-1:0]   channel_index,
    output logic                                    acc_first,
    output logic                                    acc_last
`ifdef CONV1D_IDX_PAD_EN
    , output logic                                  input_is_pad
`endif
);
`ifdef CONV1D_IDX_PAD_EN
    localparam int PadAmt = Pad;
`else
    localparam int PadAmt = 0;
`endif
    localparam int Output_Nums = calc_output_nums(Input_Nums, Weight_Nums, Dilation, Stride, PadAmt);
    localparam int Groups      = Weight_Nums / Para_Deg;
    localparam int ChW         = ch_idx_width(Channel_Nums);

    state_t state_q, state_d;
    logic   idx_valid_q, busy_q, done_q, acc_first_q, acc_last_q;
    logic [Weight_Addr_Width-1:0] weight_index_q;
    logic [Input_Addr_Width-1:0]  input_index_q;
    logic [Output_Addr_Width-1:0] output_index_q;
    logic [ChW-1:0]               channel_index_q;

    logic hs, start_acc, run_d, k_inc, c_inc, o_inc;
    logic [IdxW-1:0] k_cnt_d, k_w_off_d, k_in_off_d, c_cnt_d, c_in_base_d, c_w_base_d;
    logic [IdxW-1:0] o_cnt_d, o_in_base_d, o_unused_b_d, in_part_d;
    logic k_last_q, k_last_d, c_last_q, c_last_d, o_last_q, o_unused_last_d;

    assign hs        = idx_valid_q & idx_ready;
    assign start_acc = (state_q == IDLE) & start;
    assign k_inc     = hs;
    assign c_inc     = hs & k_last_q;
    assign o_inc     = c_inc & c_last_q;

    conv1d_nested_counter #(.Count(Groups), .Step_A(Para_Deg), .Step_B(Para_Deg * Dilation), .VW(IdxW)) u_k (
        .clk(clk), .rst(rst), .clr_i(start_acc), .inc_i(k_inc),
        .cnt_d_o(k_cnt_d), .a_d_o(k_w_off_d), .b_d_o(k_in_off_d),
        .last_q_o(k_last_q), .last_d_o(k_last_d)
    );

    conv1d_nested_counter #(.Count(Channel_Nums), .Step_A(Input_Nums), .Step_B(Weight_Nums), .VW(IdxW)) u_c (
        .clk(clk), .rst(rst), .clr_i(start_acc), .inc_i(c_inc),
        .cnt_d_o(c_cnt_d), .a_d_o(c_in_base_d), .b_d_o(c_w_base_d),
        .last_q_o(c_last_q), .last_d_o(c_last_d)
    );

    conv1d_nested_counter #(.Count(Output_Nums), .Step_A(Stride), .Step_B(0), .VW(IdxW)) u_o (
        .clk(clk), .rst(rst), .clr_i(start_acc), .inc_i(o_inc),
        .cnt_d_o(o_cnt_d), .a_d_o(o_in_base_d), .b_d_o(o_unused_b_d),
        .last_q_o(o_last_q), .last_d_o(o_unused_last_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (o_inc && o_last_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign run_d = (state_d == RUN);

`ifdef CONV1D_IDX_PAD_EN
    logic signed [IdxW:0] pos_d;
    logic                 is_pad_d, input_is_pad_q;

    // Position is taken at the group's base tap; padded taps read channel offset only.
    always_comb begin
        pos_d     = $signed({1'b0, o_in_base_d}) + $signed({1'b0, k_in_off_d}) - $signed((IdxW + 1)'(PadAmt));
        is_pad_d  = (pos_d < 0) || (pos_d >= $signed((IdxW + 1)'(Input_Nums)));
        in_part_d = is_pad_d ? '0 : pos_d[IdxW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) input_is_pad_q <= 1'b0;
        else     input_is_pad_q <= run_d & is_pad_d;
    end

    assign input_is_pad = input_is_pad_q;
`else
    assign in_part_d = o_in_base_d + k_in_off_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            acc_first_q     <= 1'b0;
            acc_last_q      <= 1'b0;
            weight_index_q  <= '0;
            input_index_q   <= '0;
            output_index_q  <= '0;
            channel_index_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_valid_q     <= run_d;
            busy_q          <= (state_d != IDLE);
            done_q          <= (state_d == DONE);
            acc_first_q     <= run_d && (k_cnt_d == '0) && (c_cnt_d == '0);
            acc_last_q      <= run_d && k_last_d && c_last_d;
            weight_index_q  <= Weight_Addr_Width'(c_w_base_d + k_w_off_d);
            input_index_q   <= Input_Addr_Width'(c_in_base_d + in_part_d);
            output_index_q  <= Output_Addr_Width'(o_cnt_d);
            channel_index_q <= ChW'(c_cnt_d);
        end
    end

    assign idx_valid     = idx_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign acc_first     = acc_first_q;
    assign acc_last      = acc_last_q;
    assign weight_index  = weight_index_q;
    assign input_index   = input_index_q;
    assign output_index  = output_index_q;
    assign channel_index = channel_index_q;

endmodule
